demux_1_8_buf: RTL



---
 rtl/demux_1_8_buf_pkg.sv | 10 +
 rtl/demux_1_8_buf_if.sv | 14 +
 rtl/demux_1_8_buf_lane.sv | 22 ++
 rtl/demux_1_8_buf.sv | 33 +++
 4 files changed

// File: rtl/demux_1_8_buf_pkg.sv
// demux_1_8_buf_pkg: shared lane-count constants and helpers for 1:N distributors and N:1 mux trees
package demux_1_8_buf_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int OCC_W = 4;
  function automatic logic [OCC_W-1:0] popcount(input logic [LANES-1:0] v);
    popcount = '0;
    for (int i = 0; i < LANES; i++) popcount += OCC_W'(v[i]);
  endfunction
endpackage

// File: rtl/demux_1_8_buf_if.sv
// demux_1_8_buf_if: producer port and eight consumer lanes of the buffered 1:8 distributor
interface demux_1_8_buf_if #(parameter int bus_size = 32);
  import demux_1_8_buf_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [bus_size-1:0] in_data;
  logic [LANES-1:0] out_valid;
  logic [LANES-1:0] out_ready;
  logic [LANES*bus_size-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
  modport master(output in_valid, in_sel, in_data, out_ready, input in_ready, out_valid, out_data, occupancy);
  modport slave(input in_valid, in_sel, in_data, out_ready, output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/demux_1_8_buf_lane.sv
// demux_lane: one-entry holding register; a load in the same cycle as a drain keeps the lane full
module demux_lane #(parameter int bus_size = 32) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic drain,
  input  logic [bus_size-1:0] d,
  output logic full,
  output logic full_next,
  output logic [bus_size-1:0] q
);
  assign full_next = load || (full && !drain);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q <= '0;
    end else begin
      full <= full_next;
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/demux_1_8_buf.sv
// demux_1_8_buf: routes each accepted word to the lane chosen by in_sel; each lane drains on its own handshake
module demux_1_8_buf import demux_1_8_buf_pkg::*; #(parameter int bus_size = 32) (
  input logic clk,
  input logic rst_n,
  demux_1_8_buf_if.slave bus
);
  logic [LANES-1:0] full, full_next, load, drain;
  logic [LANES*bus_size-1:0] data;
  logic [OCC_W-1:0] occ;
  // only the selected lane gates acceptance; its consumer's ready frees it in the same cycle
  assign bus.in_ready = !full[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign load = (bus.in_valid && bus.in_ready) ? {{(LANES-1){1'b0}}, 1'b1} << bus.in_sel : '0;
  assign drain = full & bus.out_ready;
  assign bus.out_valid = full;
  assign bus.out_data = data;
  assign bus.occupancy = occ;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane #(.bus_size(bus_size)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[i]),
      .drain(drain[i]),
      .d(bus.in_data),
      .full(full[i]),
      .full_next(full_next[i]),
      .q(data[i*bus_size +: bus_size])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= '0;
    else occ <= popcount(full_next);
  end
endmodule
